counter_updown_load: RTL and testbench
======================================

# counter_updown_load

Parametrised N-bit synchronous up/down counter with parallel load, synchronous clear, programmable terminal value and selectable wrap or saturate behaviour. It extends the enable/load ripple-carry counter family and is used for timers, dividers and address generators, with a combinational terminal-count output for cascading.

## Interface
- N, default 4: counter width in bits; legal range is 2 to 32.
- SAT, default 0: boundary mode. 0 means the counter wraps; 1 means it saturates.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- En  input  1  count enable
- load  input  1  synchronous parallel load of C
- clr  input  1  synchronous clear to 0
- up  input  1  direction: 1 counts up, 0 counts down
- C  input  N  parallel load value
- M  input  N  terminal (top) value; the count range is 0..M
- Q  output  N  counter value
- Z  output  1  terminal count, combinational
- ovf  output  1  sticky boundary-event flag

## Operation
- Reset: one clock and one reset. Reset is asynchronous and active-low. While rst_n=0: Q=0, ovf=0, and Z follows its equation using Q=0.
- Priority at each rising clk edge: clr, then load, then En. With none asserted, Q holds.
- clr=1: Q←0 and ovf←0. load and En are ignored.
- load=1 (clr=0): Q←min(C, M) and ovf←0. A C value above M is clamped to M.
- En=1, up=1:
  - If Q<M: Q←Q+1.
  - If Q≥M and SAT=0: Q←0 and ovf←1.
  - If Q≥M and SAT=1: Q←M and ovf←1.
- En=1, up=0:
  - If Q>0: Q←Q−1.
  - If Q=0 and SAT=0: Q←M and ovf←1.
  - If Q=0 and SAT=1: Q holds at 0 and ovf←1.
- A down-count from Q>M (possible after M changes at run time) decrements normally.
- Z = En & ((up & Q≥M) | (~up & Q==0)). Z is high in the cycle whose next edge produces a wrap or saturation. It carries no dependence on clr or load, so it can drive the En input of a following stage.
- ovf is sticky. It is cleared only by rst_n, clr or load.
- M=0: the up-count wraps or saturates at 0 every enabled cycle, so Z=En whenever up=1.
- All arithmetic is N-bit unsigned. No intermediate result exceeds N bits, because the boundary checks are made before the increment or decrement.

## Timing
- Q and ovf change only on a rising clk edge, or asynchronously on rst_n falling.
- Latency is 1 cycle from a sampled En, load or clr to the new Q.
- Z is combinational from Q, M, En and up, with zero-cycle latency. It is valid before the edge at which it takes effect.
- Reset release:
  - rst_n rising has no effect of its own; the first active edge is the first rising clk edge with rst_n=1.
  - Reset deasserting within the same cycle as a load or count edge is the integrator's concern; the block adds no synchroniser.
- Reset asserted mid-count forces Q=0 and ovf=0 immediately, regardless of clk.
- Simultaneous clr, load and En: clr wins, so Q=0.
- load and En together: the load wins and no count occurs that cycle.

## Test plan
- N=4, SAT=0, M=9, up=1, En=1 from reset → Q steps 0,1,…,9,0. Z=1 only while Q=9. ovf rises on the edge where Q goes 9→0.
- N=4, SAT=1, M=9, up=0, loaded C=2, En=1 → Q goes 2,1,0,0,0. Z=1 while Q=0. ovf=1 after the first held cycle.
- N=4, M=9, load=1 with C=13 → Q=9 next cycle (clamped) and ovf=0. Then clr=1 together with load=1 and En=1 → Q=0.
- N=8, SAT=0, M=255, up=0, Q=0, En=1 → Q=255 and ovf=1. Then load C=0x5A → Q=0x5A and ovf=0.
- Count to Q=7 with M=15, then assert rst_n=0 between clock edges → Q=0 and ovf=0 immediately. After release, up-count resumes from 0 on the first edge.
- Cascade two N=4, M=15, SAT=0 instances: the low stage's Z drives the high stage's En → the combined 8-bit value increments 0x00→0xFF→0x00 over 256 cycles. The high stage advances only when the low stage is at 15.

Source files
------------

// File: rtl/counter_updown_load.sv
// N-bit up/down counter with parallel load, synchronous clear, programmable
// terminal value M, wrap or saturate at the boundary, and a cascadable terminal count.
module counter_updown_load #(
  parameter int N   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         En,
  input  logic         load,
  input  logic         clr,
  input  logic         up,
  input  logic [N-1:0] C,
  input  logic [N-1:0] M,
  output logic [N-1:0] Q,
  output logic         Z,
  output logic         ovf
);

  logic [N-1:0] q_p0;
  logic         ovf_p0;
  logic [N-1:0] q_nxt;
  logic         ovf_nxt;
  logic [N:0]   step;

  // Boundary is checked before the +/-1, so the arithmetic never needs a carry bit.
  // Result is {boundary_hit, next_value}.
  function automatic logic [N:0] count_step(input logic [N-1:0] q,
                                            input logic [N-1:0] m,
                                            input logic         dir_up);
    logic [N-1:0] nxt;
    logic         hit;
    hit = 1'b0;
    nxt = q;
    if (dir_up) begin
      if (q >= m) begin
        hit = 1'b1;
        nxt = SAT ? m : {N{1'b0}};
      end else begin
        nxt = q + 1'b1;
      end
    end else begin
      if (q == {N{1'b0}}) begin
        hit = 1'b1;
        nxt = SAT ? {N{1'b0}} : m;
      end else begin
        nxt = q - 1'b1;
      end
    end
    return {hit, nxt};
  endfunction

  function automatic logic [N-1:0] load_clamp(input logic [N-1:0] c,
                                              input logic [N-1:0] m);
    return (c > m) ? m : c;
  endfunction

  always_comb begin
    q_nxt   = q_p0;
    ovf_nxt = ovf_p0;
    step    = count_step(q_p0, M, up);
    if (clr) begin
      q_nxt   = {N{1'b0}};
      ovf_nxt = 1'b0;
    end else if (load) begin
      q_nxt   = load_clamp(C, M);
      ovf_nxt = 1'b0;
    end else if (En) begin
      q_nxt   = step[N-1:0];
      ovf_nxt = ovf_p0 | step[N];
    end
  end

  // Stage p0: counter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0   <= {N{1'b0}};
      ovf_p0 <= 1'b0;
    end else begin
      q_p0   <= q_nxt;
      ovf_p0 <= ovf_nxt;
    end
  end

  // Terminal count ignores clr/load so it can feed the En of a following stage.
  assign Z   = En & ((up & (q_p0 >= M)) | (~up & (q_p0 == {N{1'b0}})));
  assign Q   = q_p0;
  assign ovf = ovf_p0;

endmodule

// File: tb/tb_counter_updown_load.sv
// Scoreboard bench for counter_updown_load: wrap/saturate 4-bit, wrap 8-bit,
// and a two-stage 4-bit cascade, all checked against a rule-level model.
module tb_counter_updown_load;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en, load, clr, up, casc_en;
  logic [7:0] c, m;
  logic [3:0] qa, qb, ql, qh;
  logic [7:0] qc;
  logic       za, zb, zc, zl, zh;
  logic       oa, ob, oc, ol, oh;

  counter_updown_load #(.N(4), .SAT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .En(en), .load(load), .clr(clr), .up(up),
    .C(c[3:0]), .M(m[3:0]), .Q(qa), .Z(za), .ovf(oa));
  counter_updown_load #(.N(4), .SAT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .En(en), .load(load), .clr(clr), .up(up),
    .C(c[3:0]), .M(m[3:0]), .Q(qb), .Z(zb), .ovf(ob));
  counter_updown_load #(.N(8), .SAT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .En(en), .load(load), .clr(clr), .up(up),
    .C(c), .M(m), .Q(qc), .Z(zc), .ovf(oc));
  counter_updown_load #(.N(4), .SAT(1'b0)) casc_lo (
    .clk(clk), .rst_n(rst_n), .En(casc_en), .load(1'b0), .clr(1'b0), .up(1'b1),
    .C(4'd0), .M(4'd15), .Q(ql), .Z(zl), .ovf(ol));
  counter_updown_load #(.N(4), .SAT(1'b0)) casc_hi (
    .clk(clk), .rst_n(rst_n), .En(zl), .load(1'b0), .clr(1'b0), .up(1'b1),
    .C(4'd0), .M(4'd15), .Q(qh), .Z(zh), .ovf(oh));

  typedef struct {
    int q;
    bit ovf;
  } st_t;

  typedef struct {
    int qa, qb, qc, casc;
    bit oa, ob, oc, za, zb, zc, zl;
  } exp_t;

  st_t  sa, sb, sc;
  int   casc;
  exp_t scb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference rules: clear, then clamped load, then count with wrap or saturate.
  function automatic st_t model_step(st_t s, int w, bit sat, bit e, bit l, bit cl,
                                     bit u, int cv, int mv);
    int  mask;
    st_t r;
    mask = (1 << w) - 1;
    cv   = cv & mask;
    mv   = mv & mask;
    r    = s;
    if (cl) begin
      r.q = 0; r.ovf = 1'b0;
    end else if (l) begin
      r.q = (cv > mv) ? mv : cv; r.ovf = 1'b0;
    end else if (e) begin
      if (u) begin
        if (s.q < mv) r.q = s.q + 1;
        else begin r.q = sat ? mv : 0; r.ovf = 1'b1; end
      end else begin
        if (s.q > 0) r.q = s.q - 1;
        else begin r.q = sat ? 0 : mv; r.ovf = 1'b1; end
      end
    end
    return r;
  endfunction

  function automatic bit model_z(st_t s, int w, bit e, bit u, int mv);
    mv = mv & ((1 << w) - 1);
    return e && ((u && s.q >= mv) || (!u && s.q == 0));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Called just after a rising edge: apply inputs, queue what the outputs must
  // read before the next edge, then advance the model across that edge.
  task automatic cyc(input bit e, input bit l, input bit cl, input bit u,
                     input int cv, input int mv, input bit ce);
    exp_t x;
    en = e; load = l; clr = cl; up = u;
    c = cv[7:0]; m = mv[7:0]; casc_en = ce;
    x.qa = sa.q; x.oa = sa.ovf; x.za = model_z(sa, 4, e, u, mv);
    x.qb = sb.q; x.ob = sb.ovf; x.zb = model_z(sb, 4, e, u, mv);
    x.qc = sc.q; x.oc = sc.ovf; x.zc = model_z(sc, 8, e, u, mv);
    x.casc = casc;
    x.zl = ce && ((casc % 16) == 15);
    scb.push_back(x);
    @(posedge clk);
    #1;
    sa = model_step(sa, 4, 1'b0, e, l, cl, u, cv, mv);
    sb = model_step(sb, 4, 1'b1, e, l, cl, u, cv, mv);
    sc = model_step(sc, 8, 1'b0, e, l, cl, u, cv, mv);
    if (ce) casc = (casc + 1) % 256;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (scb.size() > 0) begin
      x = scb.pop_front();
      chk("qa", 32'(qa), x.qa);   chk("ovf_a", 32'(oa), int'(x.oa)); chk("z_a", 32'(za), int'(x.za));
      chk("qb", 32'(qb), x.qb);   chk("ovf_b", 32'(ob), int'(x.ob)); chk("z_b", 32'(zb), int'(x.zb));
      chk("qc", 32'(qc), x.qc);   chk("ovf_c", 32'(oc), int'(x.oc)); chk("z_c", 32'(zc), int'(x.zc));
      chk("casc", 32'({qh, ql}), x.casc);
      chk("z_lo", 32'(zl), int'(x.zl));
    end
  end

  initial begin
    int mv;
    en = 0; load = 0; clr = 0; up = 0; casc_en = 0; c = 0; m = 0;
    sa = '{0, 1'b0}; sb = '{0, 1'b0}; sc = '{0, 1'b0}; casc = 0;

    // Reset state, Z following its equation with Q=0
    #12;
    chk("rst_qa", 32'(qa), 0); chk("rst_ovf_a", 32'(oa), 0);
    chk("rst_qc", 32'(qc), 0); chk("rst_ovf_c", 32'(oc), 0);
    en = 1; up = 1; m = 8'd9; #1;
    chk("rst_z_m9", 32'(za), 0);
    m = 8'd0; #1;
    chk("rst_z_m0", 32'(za), 1);
    en = 0; up = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Up-count with M=9: wrap vs saturate
    repeat (12) cyc(1, 0, 0, 1, 0, 9, 0);
    // Load 2, count down past zero
    cyc(0, 1, 0, 0, 2, 9, 0);
    repeat (5) cyc(1, 0, 0, 0, 0, 9, 0);
    // Clamped load, then clr beats load and En
    cyc(0, 1, 0, 1, 13, 9, 0);
    cyc(1, 1, 1, 1, 13, 9, 0);
    cyc(0, 0, 0, 1, 0, 9, 0);
    // Down-wrap at M=255 on the 8-bit counter, then load 0x5A
    cyc(0, 0, 1, 0, 0, 255, 0);
    cyc(1, 0, 0, 0, 0, 255, 0);
    cyc(0, 1, 0, 0, 'h5A, 255, 0);
    cyc(0, 0, 0, 0, 0, 255, 0);
    // M=0 boundary
    repeat (3) cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Q above a lowered M
    cyc(0, 1, 0, 0, 12, 15, 0);
    cyc(1, 0, 0, 0, 0, 5, 0);
    cyc(1, 0, 0, 1, 0, 5, 0);
    // Count to 7, then asynchronous reset between edges
    cyc(0, 0, 1, 1, 0, 15, 1);
    repeat (7) cyc(1, 0, 0, 1, 0, 15, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_qa", 32'(qa), 0); chk("async_ovf_a", 32'(oa), 0);
    chk("async_qb", 32'(qb), 0); chk("async_qc", 32'(qc), 0);
    chk("async_casc", 32'({qh, ql}), 0);
    sa = '{0, 1'b0}; sb = '{0, 1'b0}; sc = '{0, 1'b0}; casc = 0;
    en = 0; load = 0; clr = 0; casc_en = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) cyc(1, 0, 0, 1, 0, 15, 0);

    // Randomized mix, M changing at run time
    mv = 9;
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) mv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)), $urandom_range(0, 255), mv, 1'($urandom_range(0, 1)));
    end

    // Cascade through a full 256-count wrap
    repeat (260) cyc(0, 0, 0, 1, 0, 15, 1);

    @(negedge clk); #1;
    chk("scb_drained", 32'(scb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
